wb_port_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order writeback

---
 rtl/wb_pkg.sv | 21 ++
 rtl/lu_result_fifo.sv | 68 ++++++
 rtl/wb_port_arbiter.sv | 123 ++++++++++++
 tb/tb_wb_port_arbiter.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and widths for the register-file write-port arbiter.
package wb_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam int NREGS  = 1 << REG_W;

  typedef struct packed {
    logic              we;
    logic [REG_W-1:0]  rd;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic {
    NORMAL = 1'b0,
    STARVE = 1'b1
  } arb_state_t;

  function automatic logic [NREGS-1:0] rd_onehot(input logic [REG_W-1:0] rd);
    rd_onehot = {{(NREGS-1){1'b0}}, 1'b1} << rd;
  endfunction
endpackage

// File: rtl/lu_result_fifo.sv
// In-order FIFO of long-latency-unit results; also reports the set of
// destination registers held by valid entries.
module lu_result_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [REG_W-1:0]  push_rd_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [REG_W-1:0]  head_rd_o,
  output logic [DATA_W-1:0] head_data_o,
  output logic [NREGS-1:0]  rd_mask_o
);
  localparam int AW = $clog2(DEPTH);

  logic [REG_W-1:0]  rd_q   [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  logic [AW-1:0]     wptr_q;
  logic [AW-1:0]     rptr_q;

  // Payload storage needs no reset: valid_q qualifies every slot.
  always_ff @(posedge clk) begin
    if (push_i) begin
      rd_q[wptr_q]   <= push_rd_i;
      data_q[wptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= {DEPTH{1'b0}};
      wptr_q  <= {AW{1'b0}};
      rptr_q  <= {AW{1'b0}};
    end else begin
      if (push_i) begin
        valid_q[wptr_q] <= 1'b1;
        wptr_q          <= wptr_q + AW'(1);
      end
      if (pop_i) begin
        valid_q[rptr_q] <= 1'b0;
        rptr_q          <= rptr_q + AW'(1);
      end
    end
  end

  assign full_o      = &valid_q;
  assign empty_o     = ~|valid_q;
  assign head_rd_o   = rd_q[rptr_q];
  assign head_data_o = data_q[rptr_q];

  always_comb begin
    rd_mask_o = {NREGS{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i]) begin
        rd_mask_o = rd_mask_o | rd_onehot(rd_q[i]);
      end else begin
        rd_mask_o = rd_mask_o;
      end
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between the writeback stage (always wins)
// and queued long-latency results, with a starvation guard and pending mask.
module wb_port_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_we,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              lu_valid,
  input  logic [REG_W-1:0]  lu_rd,
  input  logic [DATA_W-1:0] lu_data,
  output logic              lu_ready,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall_req,
  output logic [NREGS-1:0]  pend_mask
);
  localparam int CW = $clog2(STARVE_LIMIT);

  logic              slot_busy_s;
  logic              push_s;
  logic              pop_s;
  logic              full_s;
  logic              empty_s;
  logic [REG_W-1:0]  head_rd_s;
  logic [DATA_W-1:0] head_data_s;
  logic [NREGS-1:0]  fifo_mask_s;
  wb_req_t           grant_s;
  wb_req_t           rf_q;
  logic              rf_lu_q;
  logic              stall_q;
  arb_state_t        state_q;
  logic [CW-1:0]     cnt_q;

  assign slot_busy_s = wb_we && (wb_rd != {REG_W{1'b0}});
  assign lu_ready    = !full_s;
  // rd0 results are acknowledged but never enter the queue.
  assign push_s      = lu_valid && !full_s && (lu_rd != {REG_W{1'b0}});
  assign pop_s       = !slot_busy_s && !empty_s;

  lu_result_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_s),
    .push_rd_i   (lu_rd),
    .push_data_i (lu_data),
    .pop_i       (pop_s),
    .full_o      (full_s),
    .empty_o     (empty_s),
    .head_rd_o   (head_rd_s),
    .head_data_o (head_data_s),
    .rd_mask_o   (fifo_mask_s)
  );

  always_comb begin
    grant_s = '{we: 1'b0, rd: rf_q.rd, data: rf_q.data};
    if (slot_busy_s) begin
      grant_s = '{we: 1'b1, rd: wb_rd, data: wb_data};
    end else if (pop_s) begin
      grant_s = '{we: 1'b1, rd: head_rd_s, data: head_data_s};
    end else begin
      grant_s.we = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_q    <= '{we: 1'b0, rd: {REG_W{1'b0}}, data: {DATA_W{1'b0}}};
      rf_lu_q <= 1'b0;
    end else begin
      rf_q    <= grant_s;
      rf_lu_q <= pop_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= NORMAL;
      cnt_q   <= {CW{1'b0}};
      stall_q <= 1'b0;
    end else begin
      case (state_q)
        NORMAL: begin
          if (pop_s || empty_s) begin
            cnt_q <= {CW{1'b0}};
          end else if (cnt_q == CW'(STARVE_LIMIT - 1)) begin
            state_q <= STARVE;
            stall_q <= 1'b1;
            cnt_q   <= {CW{1'b0}};
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        STARVE: begin
          if (pop_s) begin
            state_q <= NORMAL;
            stall_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
          end else begin
            stall_q <= 1'b1;
          end
        end
        default: begin
          state_q <= NORMAL;
          stall_q <= 1'b0;
          cnt_q   <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign rf_we     = rf_q.we;
  assign rf_waddr  = rf_q.rd;
  assign rf_wdata  = rf_q.data;
  assign stall_req = stall_q;
  assign pend_mask = fifo_mask_s | (rf_lu_q ? rd_onehot(rf_q.rd) : {NREGS{1'b0}});
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: outputs sampled 1ns after each posedge,
// inputs for the same cycle driven immediately afterwards.
module tb_wb_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lu_valid;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req;
  logic [31:0] pend_mask;

  int vecs = 0;
  int errs = 0;

  wb_port_arbiter #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk(clk), .rst(rst),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .lu_valid(lu_valid), .lu_rd(lu_rd), .lu_data(lu_data), .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_req(stall_req), .pend_mask(pend_mask)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_we = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
    lu_valid = 1'b0; lu_rd = 5'd0; lu_data = 32'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    vecs++; if (rf_we !== 1'b0) begin errs++; $display("FAIL reset_rf_we: got %0h want 0", rf_we); end
    vecs++; if (rf_waddr !== 5'd0) begin errs++; $display("FAIL reset_rf_waddr: got %0h want 0", rf_waddr); end
    vecs++; if (rf_wdata !== 32'd0) begin errs++; $display("FAIL reset_rf_wdata: got %0h want 0", rf_wdata); end
    vecs++; if (stall_req !== 1'b0) begin errs++; $display("FAIL reset_stall: got %0h want 0", stall_req); end
    vecs++; if (pend_mask !== 32'd0) begin errs++; $display("FAIL reset_pend: got %0h want 0", pend_mask); end
    vecs++; if (lu_ready !== 1'b1) begin errs++; $display("FAIL reset_lu_ready: got %0h want 1", lu_ready); end
    rst = 1'b0;
  endtask

  task automatic test_lu_only();
    lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'hDEAD;
    tick();
    idle();
    vecs++; if (pend_mask !== 32'h20) begin errs++; $display("FAIL lu_pend_t1: got %0h want 20", pend_mask); end
    vecs++; if (rf_we !== 1'b0) begin errs++; $display("FAIL lu_nobypass: got %0h want 0", rf_we); end
    tick();
    vecs++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'hDEAD}) begin
      errs++; $display("FAIL lu_write_t2: got we=%0h rd=%0d d=%0h want we=1 rd=5 d=dead", rf_we, rf_waddr, rf_wdata); end
    vecs++; if (pend_mask !== 32'h20) begin errs++; $display("FAIL lu_pend_t2: got %0h want 20", pend_mask); end
    tick();
    vecs++; if (pend_mask !== 32'd0) begin errs++; $display("FAIL lu_pend_t3: got %0h want 0", pend_mask); end
    vecs++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd5, 32'hDEAD}) begin
      errs++; $display("FAIL lu_hold_t3: got we=%0h rd=%0d d=%0h want we=0 rd=5 d=dead", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_conflict();
    wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'h11;
    lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h22;
    tick();
    idle();
    vecs++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h11}) begin
      errs++; $display("FAIL conflict_wb: got we=%0h rd=%0d d=%0h want we=1 rd=3 d=11", rf_we, rf_waddr, rf_wdata); end
    vecs++; if (pend_mask !== 32'h80) begin errs++; $display("FAIL conflict_pend: got %0h want 80", pend_mask); end
    tick();
    vecs++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h22}) begin
      errs++; $display("FAIL conflict_lu: got we=%0h rd=%0d d=%0h want we=1 rd=7 d=22", rf_we, rf_waddr, rf_wdata); end
    tick();
    vecs++; if (rf_we !== 1'b0 || pend_mask !== 32'd0) begin
      errs++; $display("FAIL conflict_done: got we=%0h pend=%0h want we=0 pend=0", rf_we, pend_mask); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      vecs++; if (lu_ready !== (i < 4)) begin errs++; $display("FAIL full_ready_%0d: got %0h want %0h", i, lu_ready, (i < 4)); end
      wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'(i);
      lu_valid = 1'b1; lu_rd = 5'(10 + i); lu_data = 32'(32'hA0 + i);
      tick();
    end
    // Still full this cycle although the first drain pops.
    vecs++; if (lu_ready !== 1'b0) begin errs++; $display("FAIL full_ready_pop: got %0h want 0", lu_ready); end
    vecs++; if (pend_mask !== 32'h3C00) begin errs++; $display("FAIL full_pend: got %0h want 3c00", pend_mask); end
    wb_we = 1'b0;
    tick();
    for (int k = 0; k < 5; k++) begin
      vecs++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'(10 + k), 32'(32'hA0 + k)}) begin
        errs++; $display("FAIL full_drain_%0d: got we=%0h rd=%0d d=%0h want we=1 rd=%0d d=%0h",
                         k, rf_we, rf_waddr, rf_wdata, 10 + k, 32'hA0 + k); end
      if (k == 0) begin
        vecs++; if (lu_ready !== 1'b1) begin errs++; $display("FAIL full_ready_after: got %0h want 1", lu_ready); end
      end else begin
        lu_valid = 1'b0;
      end
      tick();
    end
    vecs++; if (rf_we !== 1'b0 || pend_mask !== 32'd0) begin
      errs++; $display("FAIL full_done: got we=%0h pend=%0h want we=0 pend=0", rf_we, pend_mask); end
  endtask

  task automatic test_starve();
    wb_we = 1'b1; wb_rd = 5'd2; wb_data = 32'h77;
    lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'h99;
    tick();
    lu_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      vecs++; if (stall_req !== 1'b0) begin errs++; $display("FAIL starve_early_%0d: got %0h want 0", n, stall_req); end
      tick();
    end
    vecs++; if (stall_req !== 1'b1) begin errs++; $display("FAIL starve_assert: got %0h want 1", stall_req); end
    vecs++; if (pend_mask !== 32'h200) begin errs++; $display("FAIL starve_pend: got %0h want 200", pend_mask); end
    wb_we = 1'b0;
    tick();
    vecs++; if (stall_req !== 1'b0) begin errs++; $display("FAIL starve_release: got %0h want 0", stall_req); end
    vecs++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'h99}) begin
      errs++; $display("FAIL starve_drain: got we=%0h rd=%0d d=%0h want we=1 rd=9 d=99", rf_we, rf_waddr, rf_wdata); end
    tick();
    vecs++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd9, 32'h99}) begin
      errs++; $display("FAIL starve_hold: got we=%0h rd=%0d d=%0h want we=0 rd=9 d=99", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_rd0();
    wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h55;
    lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h66;
    tick();
    idle();
    vecs++; if (rf_we !== 1'b0 || pend_mask !== 32'd0) begin
      errs++; $display("FAIL rd0_t1: got we=%0h pend=%0h want we=0 pend=0", rf_we, pend_mask); end
    tick();
    vecs++; if (rf_we !== 1'b0 || pend_mask !== 32'd0) begin
      errs++; $display("FAIL rd0_t2: got we=%0h pend=%0h want we=0 pend=0", rf_we, pend_mask); end
  endtask

  task automatic test_reset_mid();
    wb_we = 1'b1; wb_rd = 5'd1; wb_data = 32'h1;
    lu_valid = 1'b1; lu_rd = 5'd20; lu_data = 32'h2020;
    tick();
    vecs++; if (pend_mask !== 32'h0010_0000) begin errs++; $display("FAIL mid_pend_before: got %0h want 100000", pend_mask); end
    rst = 1'b1;
    idle();
    tick();
    vecs++; if ({rf_we, rf_waddr, rf_wdata, pend_mask, lu_ready} !== {1'b0, 5'd0, 32'd0, 32'd0, 1'b1}) begin
      errs++; $display("FAIL mid_reset: got we=%0h rd=%0d d=%0h pend=%0h rdy=%0h want 0/0/0/0/1",
                       rf_we, rf_waddr, rf_wdata, pend_mask, lu_ready); end
    rst = 1'b0;
    tick();
    tick();
    vecs++; if (rf_we !== 1'b0 || pend_mask !== 32'd0) begin
      errs++; $display("FAIL mid_dropped: got we=%0h pend=%0h want we=0 pend=0", rf_we, pend_mask); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_lu_only();
    test_conflict();
    test_full();
    test_starve();
    test_rd0();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
